// File: rtl/bch_pkg.sv
// Shared BCH(63,51) t=2 constants and types.
// Used by the serial encoder and intended for the later syndrome/decoder stage.
//   BCH_N    : codeword length in bits
//   BCH_K    : message length in bits
//   BCH_NPAR : number of parity bits (BCH_N - BCH_K)
//   BCH_GEN  : generator polynomial, bit i = coefficient of x^i
//              g(x) = x^12 + x^10 + x^8 + x^5 + x^4 + x^3 + 1 (octal 12471)
package bch_pkg;

  localparam int          BCH_N    = 63;
  localparam int          BCH_K    = 51;
  localparam int          BCH_NPAR = 12;
  localparam logic [12:0] BCH_GEN  = 13'b1010100111001;

  // Encoder phase: passing message bits through, or emitting parity bits.
  typedef enum logic {
    PH_MSG = 1'b0,
    PH_PAR = 1'b1
  } bch_phase_t;

endpackage

// File: rtl/bch_parity_lfsr.sv
// Division LFSR holding the running parity remainder of a systematic BCH encoder.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset, clears the remainder
//   shift_en : advance the register by one bit this cycle
//   fb_en    : 1 = divide (message phase), 0 = plain shift-out (parity phase)
//   din      : incoming message bit, used only when fb_en = 1
//   clear    : synchronous clear, wins over shift_en
//   msb      : remainder bit x^(NPAR-1), i.e. the next parity bit to emit
module bch_parity_lfsr
  import bch_pkg::*;
#(
  parameter int             NPAR = BCH_NPAR,
  parameter logic [NPAR:0]  GEN  = BCH_GEN
) (
  input  logic clk,
  input  logic rst,
  input  logic shift_en,
  input  logic fb_en,
  input  logic din,
  input  logic clear,
  output logic msb
);

  logic [NPAR-1:0] rem;
  logic            fb;

  // With fb_en low the feedback is forced to zero, so the same register
  // shifts the finished remainder out MSB first during the parity phase.
  assign fb  = fb_en & (din ^ rem[NPAR-1]);
  assign msb = rem[NPAR-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= '0;
    end else if (clear) begin
      rem <= '0;
    end else if (shift_en) begin
      rem <= {rem[NPAR-2:0], 1'b0} ^ (fb ? GEN[NPAR-1:0] : '0);
    end
  end

endmodule

// File: rtl/bch_enc_serial.sv
// Serial systematic BCH(63,51), t=2 encoder.
// Each codeword is the 51 message bits passed through unchanged (first bit is
// the x^62 coefficient), followed by 12 parity bits sent x^11 first.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   valid_in  : upstream message bit valid
//   data_in   : upstream message bit
//   ready_in  : encoder accepts data_in this cycle
//   ready_out : downstream accepts data_out this cycle
//   valid_out : data_out valid
//   data_out  : codeword bit
//   last_out  : high with the 63rd (final) codeword bit
//   dbg_phase : current phase (PH_MSG / PH_PAR)
//   dbg_cnt   : bit counter within the current phase
//
// Handshake: a beat moves on a rising edge where valid and ready are both high
// on the same side; neither side may make its valid depend on seeing ready
// later. In PH_MSG the input and output handshakes are the same beat
// (zero-latency pass-through). In PH_PAR valid_out is held high, ready_in is
// low, and data_out/last_out stay fixed until ready_out takes the bit.
module bch_enc_serial
  import bch_pkg::*;
#(
  parameter int            N        = BCH_N,
  parameter int            K        = BCH_K,
  parameter logic [N-K:0]  GEN_POLY = BCH_GEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic                   data_in,
  output logic                   ready_in,
  input  logic                   ready_out,
  output logic                   valid_out,
  output logic                   data_out,
  output logic                   last_out,
  output bch_phase_t             dbg_phase,
  output logic [$clog2(N)-1:0]   dbg_cnt
);

  localparam int NPAR = N - K;
  localparam int CW   = $clog2(N);

  bch_phase_t      phase;
  logic [CW-1:0]   cnt;
  logic            xfer;
  logic            wrap;
  logic            par_msb;

  // Output muxing and transfer detection. In PH_PAR every output comes from
  // registers only; in PH_MSG the data path is combinational.
  always_comb begin
    ready_in  = 1'b0;
    valid_out = 1'b1;
    data_out  = par_msb;
    last_out  = 1'b0;
    xfer      = ready_out;
    wrap      = 1'b0;
    if (phase == PH_MSG) begin
      ready_in  = ready_out;
      valid_out = valid_in;
      data_out  = data_in;
      xfer      = valid_in && ready_out;
      wrap      = xfer && (cnt == CW'(K - 1));
    end else begin
      last_out  = (cnt == CW'(NPAR - 1));
      wrap      = xfer && last_out;
    end
  end

  // Phase FSM and per-phase bit counter; idle cycles leave state untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= PH_MSG;
      cnt   <= '0;
    end else if (xfer) begin
      if (wrap) begin
        cnt   <= '0;
        phase <= (phase == PH_MSG) ? PH_PAR : PH_MSG;
      end else begin
        cnt   <= cnt + 1'b1;
      end
    end
  end

  // The remainder is cleared on the final parity beat so a new message can
  // start on the very next cycle.
  bch_parity_lfsr #(
    .NPAR (NPAR),
    .GEN  (GEN_POLY)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (xfer),
    .fb_en    (phase == PH_MSG),
    .din      (data_in),
    .clear    (wrap && (phase == PH_PAR)),
    .msb      (par_msb)
  );

  assign dbg_phase = phase;
  assign dbg_cnt   = cnt;

endmodule

// File: doc/bch_enc_serial.md
# bch_enc_serial

Serial systematic BCH(63,51), t=2 encoder. Sits directly upstream of the channel error-injection stage, which corrupts up to two bits per 63-bit block. Consumes message bits one per handshake and emits 63-bit codewords, also one bit per handshake. Each codeword is the 51 message bits passed through unchanged, followed by 12 parity bits. Block framing is implicit: the downstream stage counts 63 accepted bits per codeword, so this block never inserts or drops bits.

## Interface
Parameters:
- N, 63, codeword length in bits
- K, 51, message length in bits
- GEN_POLY, 13'b1010100111001, generator g(x)=x^12+x^10+x^8+x^5+x^4+x^3+1 (octal 12471); bit i is the coefficient of x^i

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- valid_in  input  1  upstream message bit valid
- data_in  input  1  upstream message bit
- ready_in  output  1  encoder accepts data_in this cycle
- ready_out  input  1  downstream accepts data_out this cycle
- valid_out  output  1  data_out valid
- data_out  output  1  codeword bit
- last_out  output  1  high with the final (63rd) codeword bit

## Operation
- State: phase register {MSG, PAR}, 6-bit counter cnt, 12-bit remainder register r.
- Reset (async): phase=MSG, cnt=0, r=0.
- Reset output values (combinational from state): ready_in=ready_out, valid_out=valid_in, data_out=data_in, last_out=0.
- MSG phase, zero-latency pass-through:
  - ready_in=ready_out, valid_out=valid_in, data_out=data_in, last_out=0.
  - Transfer = valid_in && ready_out.
  - On transfer: fb=data_in^r[11]; r <= {r[10:0],1'b0} ^ (fb ? GEN_POLY[11:0] : 0); cnt++.
  - Transfer with cnt==K-1: cnt<=0, phase<=PAR.
- PAR phase:
  - ready_in=0, valid_out=1, data_out=r[11].
  - last_out=(cnt==N-K-1).
  - On ready_out: r<={r[10:0],1'b0}; cnt++.
  - Transfer with cnt==N-K-1: cnt<=0, r<=0, phase<=MSG.
- Bit order: first message bit is the x^62 coefficient; parity is sent MSB (x^11) first. The result is a systematic codeword c(x)=m(x)x^12 + (m(x)x^12 mod g(x)).
- No transfer means no state change. Gaps in valid_in mid-message are legal and do not alter the result.
- ready_out low in PAR: data_out and last_out are held unchanged.
- cnt never exceeds K-1 in MSG or N-K-1 in PAR.
- Reset mid-frame discards the partial codeword. The next accepted bit starts a fresh message.

## Timing
- MSG: combinational valid/ready/data path, 0-cycle latency; remainder updates on the accepting edge.
- The MSG→PAR switch occurs on the edge that accepts message bit 51. The first parity bit is presented the next cycle.
- With continuous valid_in and ready_out: 51 message cycles, then 12 parity cycles, exactly 63 cycles per codeword.
- Back-to-back codewords: after the last parity transfer, ready_in follows ready_out in the next cycle.
- Outputs depend combinationally on valid_in, data_in and ready_out only in MSG. In PAR they are functions of registers only.

## Structure
- Package bch_pkg holds:
  - BCH_N=63, BCH_K=51, BCH_NPAR=12, BCH_GEN=13'b1010100111001
  - typedef enum logic {PH_MSG, PH_PAR} bch_phase_t
  - These are shared with the future decoder/syndrome stage.
- Sub-module bch_parity_lfsr holds the 12-bit r register.
  - Inputs: shift_en, fb_en (MSG=1, PAR=0), din, clear.
  - Output: msb.
- The top level holds the phase FSM, counter and handshake muxing.

## Test plan
- All-zero message, continuous handshake: 63 zero bits out, last_out high only on cycle 63; the next message is accepted immediately.
- Message with only bit 51 (x^12 coefficient) set: parity stream 0,1,0,1,0,0,1,1,1,0,0,1. Also check cnt/phase and the last_out position.
- 1000 random messages against a software GF(2) model:
  - every codeword is divisible by g(x);
  - the message portion is identical to the input.
- Random valid_in gaps plus random ready_out stalls in both phases:
  - codewords match the no-stall model;
  - data_out and last_out are stable while stalled in PAR;
  - ready_in stays 0 throughout PAR.
- Assert rst asynchronously at message bit 30 and again at parity bit 5:
  - outputs return to reset values immediately;
  - the next 51 accepted bits produce a correct full codeword.
- Chain with the error-injection stage on random messages: decoding by syndrome shows at most 2 bit flips per 63-bit block, and block alignment holds over 100 codewords.
